// File: rtl/cla_add_sequencer_pkg.sv
// Shared types and defaults for the time-shared carry-lookahead wide-add sequencer.
package cla_add_sequencer_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 16;
  localparam int DEF_NREQ  = 2;
  localparam int ID_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// SLICE-bit two-level carry-lookahead adder: 4-bit groups with group propagate/generate
// feeding a group-carry lookahead unit. Purely combinational.
module cla_slice
  import cla_add_sequencer_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  localparam int NGRP = SLICE / 4;

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] c;
  logic [NGRP-1:0]  gp;
  logic [NGRP-1:0]  gg;
  logic [NGRP:0]    gc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    // NOTE: every variable gets a default before the loops so no path leaves it unassigned (no latch).
    gp = '1;
    gg = '0;
    gc = '0;
    c  = '0;
    for (int q = 0; q < NGRP; q++) begin
      for (int i = 0; i < 4; i++) begin
        gg[q] = g[4*q+i] | (p[4*q+i] & gg[q]);
        gp[q] = gp[q] & p[4*q+i];
      end
    end
    // Group-level lookahead: carries into each group depend only on group P/G and cin.
    gc[0] = cin;
    for (int q = 0; q < NGRP; q++) begin
      gc[q+1] = gg[q] | (gp[q] & gc[q]);
    end
    for (int q = 0; q < NGRP; q++) begin
      c[4*q] = gc[q];
      for (int i = 1; i < 4; i++) begin
        c[4*q+i] = g[4*q+i-1] | (p[4*q+i-1] & c[4*q+i-1]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[NGRP];

endmodule

// File: rtl/cla_add_sequencer.sv
// Round-robin sequencer that feeds one shared CLA slice a chunk per cycle, LSB first,
// chaining carries to produce a full WIDTH-bit sum on a valid/ready response port.
module cla_add_sequencer
  import cla_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf
);

  localparam int BEATS = WIDTH / SLICE;
  localparam int BW    = clog2_min1(BEATS);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            any_valid;
  logic            accept;
  logic            last_beat;
  logic [BW-1:0]   beat;
  logic            carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SLICE-1:0] s_chunk;
  logic             s_cout;

  // Search downward so the lowest offset from rr_ptr is the one left standing.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant     = ID_W'((int'(rr_ptr) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end

  assign last_beat = (beat == BW'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: if (any_valid) begin
        req_ready = NREQ'(1) << grant;
        accept    = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN:  if (last_beat) state_nxt = ST_DONE;
      ST_DONE: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state == ST_DONE);

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[beat*SLICE +: SLICE]),
    .b    (b_q[beat*SLICE +: SLICE]),
    .cin  (carry),
    .sum  (s_chunk),
    .cout (s_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      beat     <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking throughout so every register here samples pre-edge values.
      a_q    <= req_a[grant*WIDTH +: WIDTH];
      b_q    <= req_b[grant*WIDTH +: WIDTH];
      carry  <= req_cin[grant];
      beat   <= '0;
      rsp_id <= grant;
      rr_ptr <= ID_W'((int'(grant) + 1) % NREQ);
    end else if (state == ST_RUN) begin
      rsp_sum[beat*SLICE +: SLICE] <= s_chunk;
      carry <= s_cout;
      beat  <= beat + 1'b1;
      if (last_beat) begin
        rsp_cout <= s_cout;
        rsp_ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_chunk[SLICE-1] != a_q[WIDTH-1]);
      end
    end
  end

endmodule
